fetch_queue: RTL and testbench

- Consumer end of the fetch unit's PC/stall/redirect interface.
- Takes the PC each non-stalled cycle and issues an instruction-memory read with fixed latency.
- Buffers each returned instruction with its PC in a small FIFO and presents it to decode with a valid/ready handshake.
- Drives stall back to the fetch unit so the queue never overflows, and discards wrong-path work on flush.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 23 ++
 rtl/fetch_queue_inst_fifo.sv | 39 +++
 rtl/fetch_queue.sv | 56 +++++
 tb/tb_fetch_queue.sv | 98 +++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared sizing defaults and log2 helper for the fetch queue slice
package fetch_queue_pkg;
  localparam int FETCH_QUEUE_DEPTH = 4;
  localparam int IMEM_LATENCY = 1;
  localparam int FQ_DATA_WIDTH = 32;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC/stall/redirect, imem read and decode handshake bundle
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pc_in;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic stall;
  logic flush;
  logic imem_req;
  logic inst_valid;
  logic inst_ready;
  modport slave (
    input  pc_in, flush, imem_rdata, inst_ready,
    output stall, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
  modport master (
    output pc_in, flush, imem_rdata, inst_ready,
    input  stall, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_queue_inst_fifo.sv
// inst_fifo: DEPTH-entry synchronous FIFO with flush, count and combinational head
module inst_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [log2(DEPTH):0]  count_o
);
  localparam int AW = log2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign head_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  // credit upstream must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (rst) !(push_i && !pop_i && cnt_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues fixed-latency imem reads from the fetch PC and queues results for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward a return straight to decode when the FIFO is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DATA_WIDTH  = FQ_DATA_WIDTH,
  parameter int DEPTH       = FETCH_QUEUE_DEPTH,
  parameter int MEM_LATENCY = IMEM_LATENCY
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave fq
);
  localparam int CW = log2(DEPTH) + 1;
  logic [MEM_LATENCY-1:0] tv_q;
  logic [DATA_WIDTH-1:0] tpc_q [MEM_LATENCY];
  logic [CW-1:0] cnt;
  logic [2*DATA_WIDTH-1:0] head, ret_data;
  logic [CW+1:0] credit;
  logic ret, byp, push, pop, nonempty;
  assign credit = (CW+2)'(cnt) + (CW+2)'($countones(tv_q));
  assign fq.stall = !fq.flush && credit >= (CW+2)'(DEPTH);
  assign fq.imem_req = !rst && !fq.stall && !fq.flush;
  assign fq.imem_addr = rst ? '0 : fq.pc_in;
  assign ret = tv_q[MEM_LATENCY-1];
  assign ret_data = {fq.imem_rdata, tpc_q[MEM_LATENCY-1]};
  assign nonempty = cnt != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = !nonempty && ret && !fq.flush;
`else
  assign byp = 1'b0;
`endif
  assign fq.inst_valid = nonempty || byp;
  assign {fq.inst, fq.inst_pc} = nonempty ? head : byp ? ret_data : '0;
  assign push = ret && !fq.flush && !(byp && fq.inst_ready);
  assign pop = nonempty && fq.inst_ready;
  // stage 0 needs no explicit clear: imem_req is already low under rst or flush
  always_ff @(posedge clk) begin
    tv_q[0] <= fq.imem_req;
    tpc_q[0] <= fq.pc_in;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tv_q[i] <= tv_q[i-1] && !rst && !fq.flush;
      tpc_q[i] <= tpc_q[i-1];
    end
  end
  inst_fifo #(.DEPTH(DEPTH), .WIDTH(2*DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (fq.flush),
    .data_i  (ret_data),
    .head_o  (head),
    .count_o (cnt)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-based reference model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int L = IMEM_LATENCY;
  localparam int D = FETCH_QUEUE_DEPTH;
  typedef struct { logic [31:0] pc; int t; } req_t;
  logic clk = 0, rst = 1;
  fetch_queue_if #(.DATA_WIDTH(32)) bus ();
  fetch_queue #(.DATA_WIDTH(32), .DEPTH(D), .MEM_LATENCY(L)) dut (.clk(clk), .rst(rst), .fq(bus));
  always #5 clk = ~clk;
  logic [31:0] ha [L];
  logic hv [L];
  always @(posedge clk) begin
    ha[0] <= bus.imem_addr;
    hv[0] <= bus.imem_req;
    for (int i = 1; i < L; i++) begin
      ha[i] <= ha[i-1];
      hv[i] <= hv[i-1];
    end
  end
  assign bus.imem_rdata = hv[L-1] ? ha[L-1] + 32'h100 : 32'hdeadbeef;
  int tests = 0, fails = 0, ncyc = 0;
  logic [31:0] pc;
  logic [63:0] mfifo [$];
  req_t mfly [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, ncyc, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic f, input logic rdy, input logic [31:0] tgt);
    logic ret, byp, cons, e_stall, e_req, e_valid;
    logic [31:0] rpc;
    logic [63:0] e_head;
    @(negedge clk);
    rst = r;
    bus.flush = f;
    bus.inst_ready = rdy;
    bus.pc_in = pc;
    #1;
    ret = mfly.size() != 0 && ncyc - mfly[0].t == L;
    rpc = ret ? mfly[0].pc : 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = mfifo.size() == 0 && ret && !f;
`else
    byp = 1'b0;
`endif
    e_valid = mfifo.size() != 0 || byp;
    e_head = mfifo.size() != 0 ? mfifo[0] : byp ? {rpc + 32'h100, rpc} : 64'h0;
    e_stall = !f && (mfifo.size() + mfly.size() >= D);
    e_req = !r && !e_stall && !f;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    chk("imem_addr", bus.imem_addr, r ? 32'h0 : pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(e_valid));
    chk("inst", bus.inst, e_head[63:32]);
    chk("inst_pc", bus.inst_pc, e_head[31:0]);
    if (r || f) begin
      mfifo.delete();
      mfly.delete();
    end else begin
      cons = byp && rdy;
      if (mfifo.size() != 0 && rdy) void'(mfifo.pop_front());
      if (ret) begin
        if (!cons) mfifo.push_back({rpc + 32'h100, rpc});
        void'(mfly.pop_front());
      end
      if (e_req) mfly.push_back('{pc, ncyc});
    end
    @(posedge clk);
    ncyc++;
    if (f && !r) pc = tgt;
    else if (e_req) pc = pc + 1;
  endtask
  initial begin
    bus.flush = 0;
    bus.inst_ready = 0;
    pc = 32'h10;
    bus.pc_in = pc;
    repeat (2) cyc(1, 0, 0, 0);
    pc = 32'h0;
    repeat (8) cyc(0, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 32'h40);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    repeat (600) cyc($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 32'hfff));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
